tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Song-RAM driven square-wave tone player with play/pause/stop control and note articulation gaps.
// Build macro TONE_SEQ_LOOP_EN: the song repeats from address 0 instead of returning to IDLE.
module tone_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int TICK_DIV   = 6250000,
   parameter int GAP_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [10:0]       wr_data,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   output logic              speaker,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [5:0]        cur_note,
   output logic [2:0]        dbg_state
);
   localparam int TICK_W = $clog2(16 * TICK_DIV + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_FINISH} state_t;

   state_t              state_q, state_d;
   logic [10:0]         mem [2**ADDR_W];
   logic [10:0]         rd_q;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [5:0]          note_q, note_d;
   logic                spk_q, spk_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [8:0]          ncnt_q, ncnt_d, div_q, div_d;
   logic [7:0]          ocnt_q, ocnt_d, lim_q, lim_d;

   logic [5:0]          oct_w, semi_w;
   logic [8:0]          div_w;
   logic [7:0]          lim_w;
   logic [TICK_W-1:0]   tick_load;

   // RAM contents survive reset; the read port is simply registered every cycle.
   always_ff @(posedge clk) begin
      if (wr_en && state_q == S_IDLE) mem[wr_addr] <= wr_data;
      rd_q <= mem[addr_q];
   end

   always_comb begin
      oct_w     = rd_q[5:0] / 6'd12;
      semi_w    = rd_q[5:0] % 6'd12;
      lim_w     = 8'hFF >> oct_w;
      tick_load = TICK_W'((32'(rd_q[9:6]) + 32'd1) * 32'(TICK_DIV));
      unique case (semi_w)
         6'd0:    div_w = 9'd511;
         6'd1:    div_w = 9'd482;
         6'd2:    div_w = 9'd455;
         6'd3:    div_w = 9'd430;
         6'd4:    div_w = 9'd405;
         6'd5:    div_w = 9'd383;
         6'd6:    div_w = 9'd361;
         6'd7:    div_w = 9'd341;
         6'd8:    div_w = 9'd322;
         6'd9:    div_w = 9'd303;
         6'd10:   div_w = 9'd286;
         default: div_w = 9'd270;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      note_d  = note_q;
      spk_d   = spk_q;
      tick_d  = tick_q;
      gap_d   = gap_q;
      ncnt_d  = ncnt_q;
      ocnt_d  = ocnt_q;
      div_d   = div_q;
      lim_d   = lim_q;
      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         addr_d  = '0;
         note_d  = '0;
         spk_d   = 1'b0;
         tick_d  = '0;
         gap_d   = '0;
         ncnt_d  = '0;
         ocnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FETCH;
                  addr_d  = '0;
               end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               if (rd_q[10]) begin
                  state_d = S_FINISH;
                  addr_d  = '0;
               end else begin
                  state_d = S_PLAY;
                  tick_d  = tick_load;
                  ncnt_d  = '0;
                  ocnt_d  = '0;
                  div_d   = div_w;
                  lim_d   = lim_w;
                  note_d  = rd_q[5:0];
                  spk_d   = 1'b0;
               end
            end
            S_PLAY: begin
               if (!pause) begin
                  // Note divider counts 0..D; each wrap advances the octave divider 0..(255>>O).
                  if (ncnt_q == div_q) begin
                     ncnt_d = '0;
                     if (ocnt_q == lim_q) begin
                        ocnt_d = '0;
                        if (note_q != 6'd0) spk_d = ~spk_q;
                     end else begin
                        ocnt_d = ocnt_q + 8'd1;
                     end
                  end else begin
                     ncnt_d = ncnt_q + 9'd1;
                  end
                  if (tick_q <= TICK_W'(1)) begin
                     state_d = S_GAP;
                     tick_d  = '0;
                     spk_d   = 1'b0;
                     note_d  = '0;
                     gap_d   = GAP_W'(GAP_CYCLES);
                  end else begin
                     tick_d = tick_q - TICK_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (!pause) begin
                  if (gap_q <= GAP_W'(1)) begin
                     gap_d = '0;
                     if (addr_q == {ADDR_W{1'b1}}) begin
                        state_d = S_FINISH;
                        addr_d  = '0;
                     end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + ADDR_W'(1);
                     end
                  end else begin
                     gap_d = gap_q - GAP_W'(1);
                  end
               end
            end
            S_FINISH: begin
`ifdef TONE_SEQ_LOOP_EN
               state_d = S_FETCH;
`else
               state_d = S_IDLE;
`endif
               addr_d  = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         note_q  <= '0;
         spk_q   <= 1'b0;
         tick_q  <= '0;
         gap_q   <= '0;
         ncnt_q  <= '0;
         ocnt_q  <= '0;
         div_q   <= '0;
         lim_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         note_q  <= note_d;
         spk_q   <= spk_d;
         tick_q  <= tick_d;
         gap_q   <= gap_d;
         ncnt_q  <= ncnt_d;
         ocnt_q  <= ocnt_d;
         div_q   <= div_d;
         lim_q   <= lim_d;
      end
   end

   assign speaker   = spk_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FINISH);
   assign cur_addr  = addr_q;
   assign cur_note  = note_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: pitch timing, rests, pause, stop, write lockout, async reset, song end.
module tb_tone_sequencer;
   localparam int ADDR_W     = 8;
   localparam int TICK_DIV   = 8192;
   localparam int GAP_CYCLES = 4;
`ifdef TONE_SEQ_LOOP_EN
   localparam int  NLOOP    = 3;
   localparam logic BUSY_END = 1'b1;
`else
   localparam int  NLOOP    = 1;
   localparam logic BUSY_END = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              RESET;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [10:0]       wr_data;
   logic              start, pause, stop;
   logic              speaker, busy, done;
   logic [ADDR_W-1:0] cur_addr;
   logic [5:0]        cur_note;
   logic [2:0]        dbg_state;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int d0, hits;

   tone_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .pause(pause), .stop(stop), .speaker(speaker), .busy(busy),
      .done(done), .cur_addr(cur_addr), .cur_note(cur_note), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_seen++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [10:0] d);
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      step(1);
      stop = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; pause = 1'b0; stop = 1'b0;
      step(2);
      check("rst_busy", busy, 0);
      check("rst_spk", speaker, 0);
      check("rst_done", done, 0);
      check("rst_addr", cur_addr, 0);
      check("rst_note", cur_note, 0);
      RESET = 1'b0;
      step(1);

      // Single note 60 (A, octave 5): half period 512*8 = 4096 cycles, one tick = 8192 cycles.
      wr(0, 11'd60);
      wr(1, 11'h400);
      go();
      check("t1_busy", busy, 1);
      step(2);
      check("t1_note", cur_note, 60);
      check("t1_spk0", speaker, 0);
      step(4095);
      check("t1_pre_tog", speaker, 0);
      step(1);
      check("t1_tog1", speaker, 1);
      step(4095);
      check("t1_pre_gap", speaker, 1);
      check("t1_note_play", cur_note, 60);
      step(1);
      check("t1_gap_spk", speaker, 0);
      check("t1_gap_note", cur_note, 0);
      d0 = done_seen;
      step(4);
      check("t1_next_addr", cur_addr, 1);
      check("t1_done_early", done, 0);
      step(2);
      check("t1_done", done, 1);
      step(1);
      check("t1_done_end", done, 0);
      check("t1_busy_end", busy, BUSY_END);
      check("t1_addr_end", cur_addr, 0);
      check("t1_done_cnt", done_seen - d0, 1);
      halt();

      // Rest of 4 ticks, then a sounding note aborted by stop; a write while busy must be ignored.
      wr(0, 11'h0C0);
      wr(1, 11'd60);
      wr(2, 11'h400);
      go();
      step(2);
      check("t2_rest_note", cur_note, 0);
      check("t2_rest_state", dbg_state, 3);
      hits = 0;
      for (int i = 0; i < 32767; i++) begin
         step(1);
         if (speaker !== 1'b0 || cur_note !== 6'd0) hits++;
      end
      check("t2_rest_quiet", hits, 0);
      check("t2_rest_addr", cur_addr, 0);
      step(1);
      check("t2_gap", dbg_state, 4);
      step(4);
      check("t2_adv_addr", cur_addr, 1);
      step(2);
      check("t2_note2", cur_note, 60);
      step(4096);
      check("t2_tog", speaker, 1);
      d0 = done_seen;
      wr(0, 11'h400);
      halt();
      check("t2_stop_busy", busy, 0);
      check("t2_stop_spk", speaker, 0);
      check("t2_stop_addr", cur_addr, 0);
      check("t2_stop_note", cur_note, 0);
      step(10);
      check("t2_stop_nodone", done_seen - d0, 0);
      go();
      step(2);
      check("t2_replay_state", dbg_state, 3);
      step(3);
      check("t2_replay_busy", busy, 1);
      check("t2_replay_nodone", done_seen - d0, 0);
      halt();

      // Pause 1000 cycles while speaker is high: toggle and note end both slip by 1000.
      wr(0, 11'd60);
      wr(1, 11'h400);
      go();
      step(2);
      step(4500);
      check("t3_spk_hi", speaker, 1);
      pause = 1'b1;
      hits = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (speaker !== 1'b1 || dbg_state !== 3'd3) hits++;
      end
      pause = 1'b0;
      check("t3_pause_hold", hits, 0);
      step(3691);
      check("t3_pre_tog", speaker, 1);
      check("t3_pre_note", cur_note, 60);
      step(1);
      check("t3_tog", speaker, 0);
      check("t3_gap_note", cur_note, 0);
      check("t3_gap_busy", busy, 1);
      step(1);
      #2 RESET = 1'b1;
      #1;
      check("t3_arst_busy", busy, 0);
      check("t3_arst_state", dbg_state, 0);
      check("t3_arst_spk", speaker, 0);
      check("t3_arst_addr", cur_addr, 0);
      check("t3_arst_done", done, 0);
      step(1);
      RESET = 1'b0;
      step(1);

      // Two-entry song + END: done on each pass end; with looping, busy holds across passes.
      wr(0, 11'd60);
      wr(1, 11'd0);
      wr(2, 11'h400);
      d0 = done_seen;
      go();
      for (int k = 0; k < NLOOP; k++) begin
         step(16397);
         check("t4_pre_done", done, 0);
         step(1);
         check("t4_done", done, 1);
         check("t4_addr0", cur_addr, 0);
         step(1);
         check("t4_busy", busy, BUSY_END);
      end
      check("t4_done_cnt", done_seen - d0, NLOOP);
      halt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
